// File: rtl/re_name_preg_alloc.sv
// Physical-register tag allocator: lowest free tag granted in the same cycle, commit frees, flush restores the committed map.
// Grant is combinational and state updates on the next edge. There is no request queue: an empty pool or a flush denies the grant.
module re_name_preg_alloc #(
    parameter int NR_PREGS        = 64,
    parameter int NR_AREGS        = 32,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int TAG_W           = $clog2(NR_PREGS)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             alloc_req_i,
    output logic                             alloc_gnt_o,
    output logic [TAG_W-1:0]                 alloc_tag_o,
    input  logic [NR_COMMIT_PORTS-1:0]       commit_valid_i,
    input  logic [NR_COMMIT_PORTS*TAG_W-1:0] commit_new_tag_i,
    input  logic [NR_COMMIT_PORTS*TAG_W-1:0] commit_old_tag_i,
    output logic [TAG_W:0]                   free_count_o,
    output logic                             empty_o
);

    localparam logic [NR_PREGS-1:0] RESET_MAP =
        {{(NR_PREGS-NR_AREGS){1'b0}}, {NR_AREGS{1'b1}}};

    logic [NR_PREGS-1:0] spec_busy_q, spec_busy_n;
    logic [NR_PREGS-1:0] arch_busy_q, arch_busy_n;
    logic [TAG_W-1:0]    new_tag [NR_COMMIT_PORTS];
    logic [TAG_W-1:0]    old_tag [NR_COMMIT_PORTS];
    logic [TAG_W-1:0]    free_tag;
    logic [TAG_W:0]      free_cnt;

    always_comb begin
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            new_tag[p] = commit_new_tag_i[p*TAG_W +: TAG_W];
            old_tag[p] = commit_old_tag_i[p*TAG_W +: TAG_W];
        end
    end

    // Descending scan: the last hit written is the lowest free index.
    always_comb begin
        free_tag = '0;
        free_cnt = '0;
        for (int i = NR_PREGS-1; i >= 0; i--) begin
            if (!spec_busy_q[i]) begin
                free_tag = TAG_W'(i);
            end
        end
        for (int i = 0; i < NR_PREGS; i++) begin
            free_cnt = free_cnt + {{TAG_W{1'b0}}, ~spec_busy_q[i]};
        end
    end

    assign free_count_o = free_cnt;
    assign empty_o      = (free_cnt == '0);
    assign alloc_tag_o  = free_tag;
    assign alloc_gnt_o  = alloc_req_i & ~empty_o & ~flush_i;

    always_comb begin
        spec_busy_n = spec_busy_q;
        arch_busy_n = arch_busy_q;
        if (alloc_gnt_o) begin
            spec_busy_n[free_tag] = 1'b1;
        end
        // Tag 0 is the hardwired zero register and is never released.
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (commit_valid_i[p]) begin
                arch_busy_n[new_tag[p]] = 1'b1;
                if (old_tag[p] != '0) begin
                    arch_busy_n[old_tag[p]] = 1'b0;
                    spec_busy_n[old_tag[p]] = 1'b0;
                end
            end
        end
        if (flush_i) begin
            spec_busy_n = arch_busy_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            spec_busy_q <= RESET_MAP;
            arch_busy_q <= RESET_MAP;
        end else begin
            spec_busy_q <= spec_busy_n;
            arch_busy_q <= arch_busy_n;
        end
    end

    for (genvar p = 0; p < NR_COMMIT_PORTS; p++) begin : g_chk
        a_old_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (commit_valid_i[p] && old_tag[p] != '0) |-> arch_busy_q[old_tag[p]]);
        a_new_spec: assert property (@(posedge clk_i) disable iff (!rst_ni)
            commit_valid_i[p] |-> spec_busy_q[new_tag[p]]);
        for (genvar q = p + 1; q < NR_COMMIT_PORTS; q++) begin : g_pair
            a_dup_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(commit_valid_i[p] && commit_valid_i[q] &&
                  old_tag[p] == old_tag[q] && old_tag[p] != '0));
        end
    end

    a_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        free_count_o <= (TAG_W+1)'(NR_PREGS-1));

endmodule
